// File: rtl/branch_cmp_seq_if.sv
// ============================================================================
//  Module      : branch_cmp_seq_if
//  Description : Request/flag bundle between the register-read stage and the
//                iterative branch comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_cmp_seq_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            kill_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            busy_o;
    logic            valid_o;
    logic            equ_o;
    logic            lt_o;
    logic            ltu_o;

    modport master (
        output start_i, kill_i, rs1_i, rs2_i,
        input  busy_o, valid_o, equ_o, lt_o, ltu_o
    );

    modport slave (
        input  start_i, kill_i, rs1_i, rs2_i,
        output busy_o, valid_o, equ_o, lt_o, ltu_o
    );
endinterface

`default_nettype wire

// File: rtl/branch_cmp_seq.sv
// ============================================================================
//  Module      : branch_cmp_seq
//  Description : MSB-first chunked comparator producing equ/lt/ltu flags.
//                Optional macro BRANCH_CMP_EARLY_EXIT_EN ends RUN at the
//                first differing chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cmp_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 4
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    branch_cmp_seq_if.slave     bus
);

    localparam int              c_N    = XLEN / CHUNK;
    localparam int              c_KW   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_sa;
    logic               r_sb;
    logic               r_found;
    logic               r_ltu_d;
    logic [c_KW-1:0]    r_k;
    logic               r_busy;
    logic               r_valid;
    logic               r_equ;
    logic               r_lt;
    logic               r_ltu;

    logic [CHUNK-1:0]   w_ca;
    logic [CHUNK-1:0]   w_cb;
    logic               w_diff;
    logic               w_found_n;
    logic               w_ltu_n;
    logic               w_lt_n;
    logic               w_last;
    logic               w_exit;

    // Operands shift left each RUN cycle, so the active chunk is always on top.
    assign w_ca      = r_a[XLEN-1 -: CHUNK];
    assign w_cb      = r_b[XLEN-1 -: CHUNK];
    assign w_diff    = (w_ca != w_cb) && !r_found;
    assign w_found_n = r_found | w_diff;
    assign w_ltu_n   = w_diff ? (w_ca < w_cb) : r_ltu_d;
    assign w_lt_n    = w_ltu_n ^ (r_sa ^ r_sb);
    assign w_last    = (r_k == c_LAST);

`ifdef BRANCH_CMP_EARLY_EXIT_EN
    assign w_exit    = w_last | w_diff;
`else
    assign w_exit    = w_last;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_found <= 1'b0;
            r_ltu_d <= 1'b0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_equ   <= 1'b0;
            r_lt    <= 1'b0;
            r_ltu   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i && !bus.kill_i) begin
                        r_a     <= bus.rs1_i;
                        r_b     <= bus.rs2_i;
                        r_sa    <= bus.rs1_i[XLEN-1];
                        r_sb    <= bus.rs2_i[XLEN-1];
                        r_found <= 1'b0;
                        r_ltu_d <= 1'b0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.kill_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_a     <= r_a << CHUNK;
                        r_b     <= r_b << CHUNK;
                        r_k     <= r_k + 1'b1;
                        r_found <= w_found_n;
                        r_ltu_d <= w_ltu_n;
                        if (w_exit) begin
                            r_equ   <= ~w_found_n;
                            r_lt    <= w_lt_n;
                            r_ltu   <= w_ltu_n;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o  = r_busy;
    assign bus.valid_o = r_valid;
    assign bus.equ_o   = r_equ;
    assign bus.lt_o    = r_lt;
    assign bus.ltu_o   = r_ltu;

endmodule

`default_nettype wire

// File: tb/tb_branch_cmp_seq.sv
// ============================================================================
//  Module      : tb_branch_cmp_seq
//  Description : Self-checking bench for branch_cmp_seq (XLEN=32, CHUNK=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_cmp_seq;

    localparam int XLEN  = 32;
    localparam int CHUNK = 4;
    localparam int N     = XLEN / CHUNK;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic p_equ, p_lt, p_ltu;

    branch_cmp_seq_if #(.XLEN(XLEN)) bus ();

    branch_cmp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BRANCH_CMP_EARLY_EXIT_EN
        logic [31:0] x;
        x = a ^ b;
        for (int d = 0; d < N; d++)
            if (x[XLEN-1-d*CHUNK -: CHUNK] != '0) return d + 1;
        return N;
`else
        return N;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a compare from IDLE/DONE and follow it to its valid pulse.
    task automatic do_cmp(input logic [31:0] a, input logic [31:0] b);
        int n;
        int lat;
        lat = exp_lat(a, b);
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 0;
        while (bus.valid_o !== 1'b1 && n < 4 * N) begin
            chk("busy_in_run", bus.busy_o, 1);
            tick();
            n++;
        end
        chk("latency", n, lat);
        chk("valid_pulse", bus.valid_o, 1);
        chk("busy_in_done", bus.busy_o, 0);
        p_equ = (a == b);
        p_lt  = ($signed(a) < $signed(b));
        p_ltu = (a < b);
        chk("equ", bus.equ_o, p_equ);
        chk("lt", bus.lt_o, p_lt);
        chk("ltu", bus.ltu_o, p_ltu);
    endtask

    task automatic idle_check();
        tick();
        chk("valid_one_cycle", bus.valid_o, 0);
        chk("busy_idle", bus.busy_o, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        int          mode;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        p_equ = 1'b0; p_lt = 1'b0; p_ltu = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_flags", {bus.equ_o, bus.lt_o, bus.ltu_o}, 0);
        rst = 1'b0;
        tick();

        do_cmp(32'h0000_0005, 32'h0000_0005);
        idle_check();
        do_cmp(32'hFFFF_FFFF, 32'h0000_0001);
        idle_check();
        do_cmp(32'h0000_0010, 32'h0000_0020);
        idle_check();
        do_cmp(32'h7FFF_FFFF, 32'h8000_0000);
        do_cmp(32'h0000_0000, 32'h0000_0000);
        idle_check();

        // Kill mid-run with an ignored start on RUN cycle 2; flags must hold.
        bus.rs1_i = 32'h1; bus.rs2_i = 32'h2; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.rs1_i = 32'h9; bus.rs2_i = 32'h9; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b1;
        tick();
        bus.kill_i  = 1'b0;
        chk("kill_busy", bus.busy_o, 0);
        chk("kill_valid", bus.valid_o, 0);
        chk("kill_flags_hold", {bus.equ_o, bus.lt_o, bus.ltu_o}, {p_equ, p_lt, p_ltu});
        for (int i = 0; i < N + 2; i++) begin
            tick();
            chk("kill_no_valid", bus.valid_o, 0);
            chk("kill_stays_idle", bus.busy_o, 0);
        end

        // Asynchronous reset in the middle of a RUN.
        do_cmp(32'h8000_0000, 32'h7FFF_FFFF);
        idle_check();
        bus.rs1_i = 32'h3; bus.rs2_i = 32'h5; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            {bus.busy_o, bus.valid_o, bus.equ_o, bus.lt_o, bus.ltu_o}, 0);
        p_equ = 1'b0; p_lt = 1'b0; p_ltu = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("after_rst_valid", bus.valid_o, 0);
        do_cmp(32'h3, 32'h3);
        idle_check();

        for (int i = 0; i < 24; i++) begin
            a    = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       b = $urandom;
                1:       b = a;
                2:       b = a ^ ({28'd0, 4'($urandom_range(1, 15))} << (CHUNK * $urandom_range(0, N - 1)));
                default: b = a ^ 32'h8000_0000;
            endcase
            do_cmp(a, b);
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
